fp_compare_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 comparator for any binary format (default binary64). It accepts operand pairs through a valid/ready handshake and produces a mutually exclusive result of equal, less, greater or unordered. It also produces a min or max result value, with NaN and signed-zero semantics. It sits in the FP datapath and supersedes the combinational double-precision comparator. Sustained throughput is one compare per cycle.

---
 rtl/fp_cmp_pkg.sv | 24 ++
 rtl/fp_compare_pipe_classify.sv | 25 ++
 rtl/fp_compare_pipe.sv | 132 +++++++++++++
 tb/tb_fp_compare_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared types and constants for the pipelined IEEE-754 comparator.
// The operand format is set by EXP_W/MAN_W on the modules that import this package.
package fp_cmp_pkg;

  localparam logic [1:0] MODE_CMP = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;

  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_class_t;

  // Widest legal format is 1+15+112 = 128 bits; callers truncate to their own width.
  function automatic logic [127:0] canonical_qnan(input int exp_w, input int man_w);
    logic [127:0] exp_ones;
    exp_ones = (128'd1 << exp_w) - 128'd1;
    return (exp_ones << man_w) | (128'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_compare_pipe_classify.sv
// Combinational field decode of one IEEE-754 operand into sign/zero/inf/NaN/sNaN.
module fp_classify
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] x,
  output fp_class_t    cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = x[W-2 -: EXP_W];
  assign man_f = x[MAN_W-1:0];

  assign cls.sign    = x[W-1];
  assign cls.is_zero = (exp_f == '0) && (man_f == '0);
  assign cls.is_inf  = (&exp_f) && (man_f == '0);
  assign cls.is_nan  = (&exp_f) && (man_f != '0);
  assign cls.is_snan = cls.is_nan && !man_f[MAN_W-1];

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined IEEE-754 comparator with minNum/maxNum result; two register stages,
// valid/ready on both sides, one compare per cycle when the sink keeps up.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         equal_to,
  output logic         less_than,
  output logic         greater_than,
  output logic         unordered,
  output logic         invalid,
  output logic [W-1:0] minmax_out
);

  localparam logic [W-1:0] QNAN = W'(canonical_qnan(EXP_W, MAN_W));

  fp_class_t    cls_a, cls_b;
  logic         s1_valid;
  logic [W-1:0] s1_a, s1_b;
  logic [1:0]   s1_mode;
  fp_class_t    s1_ca, s1_cb;
  logic         s2_adv;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(a_in), .cls(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(b_in), .cls(cls_b));

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_CMP;
      s1_ca    <= '0;
      s1_cb    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= a_in;
        s1_b    <= b_in;
        s1_mode <= mode;
        s1_ca   <= cls_a;
        s1_cb   <= cls_b;
      end
    end
  end

  logic [W-2:0] mag_a, mag_b;
  logic         is_min, is_mm, both_zero;
  logic         eq_c, lt_c, gt_c, un_c, inv_c;
  logic [W-1:0] mm_c;

  assign mag_a     = s1_a[W-2:0];
  assign mag_b     = s1_b[W-2:0];
  assign is_min    = (s1_mode == MODE_MIN);
  assign is_mm     = is_min || (s1_mode == MODE_MAX);
  assign both_zero = s1_ca.is_zero && s1_cb.is_zero;

  always_comb begin
    eq_c  = 1'b0;
    lt_c  = 1'b0;
    gt_c  = 1'b0;
    un_c  = 1'b0;
    inv_c = s1_ca.is_snan || s1_cb.is_snan;
    mm_c  = s1_a;
    if (s1_ca.is_nan || s1_cb.is_nan) begin
      un_c = 1'b1;
    end else if (both_zero ||
                 (s1_ca.is_inf && s1_cb.is_inf && s1_ca.sign == s1_cb.sign)) begin
      eq_c = 1'b1;
    end else if (s1_ca.sign != s1_cb.sign) begin
      lt_c = s1_ca.sign;
      gt_c = !s1_ca.sign;
    end else if (mag_a == mag_b) begin
      eq_c = 1'b1;
    end else begin
      // sign-magnitude: for negatives the larger magnitude is the smaller value
      lt_c = (mag_a < mag_b) ^ s1_ca.sign;
      gt_c = !lt_c;
    end

    if (is_mm) begin
      if (s1_ca.is_nan && s1_cb.is_nan)
        mm_c = QNAN;
      else if (s1_ca.is_nan)
        mm_c = s1_b;
      else if (s1_cb.is_nan)
        mm_c = s1_a;
      else if (eq_c)
        mm_c = (both_zero && (is_min != s1_ca.sign)) ? s1_b : s1_a;
      else
        mm_c = (lt_c == is_min) ? s1_a : s1_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      equal_to     <= 1'b0;
      less_than    <= 1'b0;
      greater_than <= 1'b0;
      unordered    <= 1'b0;
      invalid      <= 1'b0;
      minmax_out   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        equal_to     <= eq_c;
        less_than    <= lt_c;
        greater_than <= gt_c;
        unordered    <= un_c;
        invalid      <= inv_c;
        minmax_out   <= mm_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: binary64 instance against a real-arithmetic
// model plus a binary32 instance for format and mid-stream reset checks.
module tb_fp_compare_pipe;

  typedef struct packed {
    logic eq, lt, gt, un, inv;
    logic [63:0] mm;
  } res_t;

  typedef struct packed {
    logic [63:0] a, b;
    logic [1:0]  m;
    res_t        r;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v64, ir64, ov64, ordy64, eq64, lt64, gt64, un64, inv64;
  logic [63:0] a64, b64, mm64;
  logic [1:0]  m64;
  logic        v32, ir32, ov32, ordy32, eq32, lt32, gt32, un32, inv32;
  logic [31:0] a32, b32, mm32;
  logic [1:0]  m32;

  fp_compare_pipe dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(ir64), .a_in(a64), .b_in(b64),
    .mode(m64), .out_valid(ov64), .out_ready(ordy64), .equal_to(eq64), .less_than(lt64),
    .greater_than(gt64), .unordered(un64), .invalid(inv64), .minmax_out(mm64));

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .a_in(a32), .b_in(b32),
    .mode(m32), .out_valid(ov32), .out_ready(ordy32), .equal_to(eq32), .less_than(lt32),
    .greater_than(gt32), .unordered(un32), .invalid(inv32), .minmax_out(mm32));

  // Reference: NaN classes from the fields, ordering and min/max from real arithmetic.
  function automatic res_t ref64(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m);
    res_t r;
    real ra, rb;
    logic na, nb;
    r = '0;
    na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'h0);
    nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'h0);
    r.inv = (na && !a[51]) || (nb && !b[51]);
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    if (na || nb) r.un = 1'b1;
    else begin
      r.eq = (ra == rb);
      r.lt = (ra < rb);
      r.gt = (ra > rb);
    end
    r.mm = a;
    if (m == 2'b01 || m == 2'b10) begin
      if (na && nb) r.mm = 64'h7FF8000000000000;
      else if (na) r.mm = b;
      else if (nb) r.mm = a;
      else if (ra < rb) r.mm = (m == 2'b01) ? a : b;
      else if (ra > rb) r.mm = (m == 2'b01) ? b : a;
      else if (ra == 0.0) begin
        if (m == 2'b01) r.mm = a[63] ? a : b;
        else r.mm = a[63] ? b : a;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: x = {x[63], 63'h0};
      1: x = {x[63], 11'h7FF, 52'h0};
      2: x = {x[63], 11'h7FF, 1'b1, x[50:0]};
      3: x = {x[63], 11'h7FF, 1'b0, x[50:1], 1'b1};
      4: x = {x[63], 11'h000, x[51:0]};
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [63:0] rand_b(input logic [63:0] a);
    case ($urandom_range(0, 7))
      0: return a;
      1: return {~a[63], a[62:0]};
      2: return {a[63:52], $urandom, 20'($urandom)};
      default: return rand_op();
    endcase
  endfunction

  task automatic step64(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] m, input logic ordy,
                        output logic acc, output logic drn, output logic ov, output res_t obs);
    @(negedge clk);
    v64 = v; a64 = a; b64 = b; m64 = m; ordy64 = ordy;
    #1;
    acc = v64 && ir64;
    drn = ov64 && ordy64;
    ov  = ov64;
    obs = {eq64, lt64, gt64, un64, inv64, mm64};
    @(posedge clk);
  endtask

  task automatic step32(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] m, input logic ordy,
                        output logic acc, output logic drn, output logic ov, output logic [36:0] obs);
    @(negedge clk);
    v32 = v; a32 = a; b32 = b; m32 = m; ordy32 = ordy;
    #1;
    acc = v32 && ir32;
    drn = ov32 && ordy32;
    ov  = ov32;
    obs = {eq32, lt32, gt32, un32, inv32, mm32};
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if ({ov64, eq64, lt64, gt64, un64, inv64, mm64} !== 70'h0) begin
      mismatched++;
      $display("FAIL reset64_outputs: got %h expected 0", {ov64, eq64, lt64, gt64, un64, inv64, mm64});
    end
    compared++;
    if ({ov32, eq32, lt32, gt32, un32, inv32, mm32} !== 38'h0) begin
      mismatched++;
      $display("FAIL reset32_outputs: got %h expected 0", {ov32, eq32, lt32, gt32, un32, inv32, mm32});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if ({ir64, ir32} !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b expected 11", {ir64, ir32});
    end
  endtask

  task automatic test_directed();
    vec_t vt[12];
    logic acc, drn, ov;
    res_t obs;
    vt[0]  = {64'h401599999999999A, 64'h401599999999999A, 2'b00, 5'b10000, 64'h401599999999999A};
    vt[1]  = {64'hC019333333333333, 64'hC01CCCCCCCCCCCCD, 2'b10, 5'b00100, 64'hC019333333333333};
    vt[2]  = {64'hC019333333333333, 64'hC01CCCCCCCCCCCCD, 2'b01, 5'b00100, 64'hC01CCCCCCCCCCCCD};
    vt[3]  = {64'h0000000000000000, 64'h8000000000000000, 2'b00, 5'b10000, 64'h0000000000000000};
    vt[4]  = {64'h0000000000000000, 64'h8000000000000000, 2'b01, 5'b10000, 64'h8000000000000000};
    vt[5]  = {64'h8000000000000000, 64'h0000000000000000, 2'b10, 5'b10000, 64'h0000000000000000};
    vt[6]  = {64'h7FF8000000000000, 64'h3FF0000000000000, 2'b01, 5'b00010, 64'h3FF0000000000000};
    vt[7]  = {64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00, 5'b00011, 64'h7FF0000000000001};
    vt[8]  = {64'h7FF8000000000123, 64'hFFF8000000000000, 2'b10, 5'b00010, 64'h7FF8000000000000};
    vt[9]  = {64'h3FF0000000000000, 64'h4000000000000000, 2'b11, 5'b01000, 64'h3FF0000000000000};
    vt[10] = {64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, 2'b01, 5'b00100, 64'h7FEFFFFFFFFFFFFF};
    vt[11] = {64'h0000000000000001, 64'h8000000000000001, 2'b10, 5'b00100, 64'h0000000000000001};
    for (int i = 0; i < 12; i++) begin
      step64(1'b1, vt[i].a, vt[i].b, vt[i].m, 1'b1, acc, drn, ov, obs);
      step64(1'b0, 64'h0, 64'h0, 2'b00, 1'b1, acc, drn, ov, obs);
      compared++;
      if (ov !== 1'b0) begin
        mismatched++;
        $display("FAIL dir%0d_early_valid: got %b expected 0", i, ov);
      end
      step64(1'b0, 64'h0, 64'h0, 2'b00, 1'b1, acc, drn, ov, obs);
      compared++;
      if (ov !== 1'b1 || obs !== vt[i].r) begin
        mismatched++;
        $display("FAIL dir%0d_result: got valid=%b %h expected valid=1 %h", i, ov, obs, vt[i].r);
      end
      step64(1'b0, 64'h0, 64'h0, 2'b00, 1'b1, acc, drn, ov, obs);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] pa[6], pb[6];
    logic [1:0]  pm[6];
    res_t q[$];
    res_t obs, prev, exp_r;
    logic acc, drn, ov, stalled;
    int idx = 0, drained = 0, k;
    stalled = 1'b0;
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      pa[i] = rand_op(); pb[i] = rand_b(pa[i]); pm[i] = 2'($urandom_range(0, 3));
    end
    for (int c = 0; c < 40 && drained < 6; c++) begin
      k = (idx < 6) ? idx : 0;
      step64(idx < 6, pa[k], pb[k], pm[k], c >= 4, acc, drn, ov, obs);
      if (stalled) begin
        compared++;
        if (ov !== 1'b1 || obs !== prev) begin
          mismatched++;
          $display("FAIL bp_hold: got valid=%b %h expected valid=1 %h", ov, obs, prev);
        end
      end
      if (drn) begin
        compared++;
        exp_r = (q.size() != 0) ? q.pop_front() : '1;
        if (obs !== exp_r) begin
          mismatched++;
          $display("FAIL bp_result%0d: got %h expected %h", drained, obs, exp_r);
        end
        drained++;
      end
      if (acc) begin
        q.push_back(ref64(pa[k], pb[k], pm[k]));
        idx++;
      end
      if (c == 3) begin
        compared++;
        if (idx != 2) begin
          mismatched++;
          $display("FAIL bp_accepts_while_stalled: got %0d expected 2", idx);
        end
      end
      stalled = ov && (c < 4);
      prev = obs;
    end
    compared++;
    if (drained != 6 || idx != 6) begin
      mismatched++;
      $display("FAIL bp_count: got accepted=%0d drained=%0d expected 6/6", idx, drained);
    end
  endtask

  task automatic test_soak();
    res_t q[$];
    res_t obs, prev, exp_r;
    logic acc, drn, ov, stalled, v, r;
    logic [63:0] a, b;
    logic [1:0] m;
    int n_acc = 0, cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while ((n_acc < 10000 || q.size() != 0) && cyc < 60000) begin
      a = rand_op();
      b = rand_b(a);
      m = 2'($urandom_range(0, 3));
      v = (n_acc < 10000) && ($urandom_range(0, 3) != 0);
      r = (n_acc >= 10000) || ($urandom_range(0, 3) != 0);
      step64(v, a, b, m, r, acc, drn, ov, obs);
      if (stalled) begin
        compared++;
        if (ov !== 1'b1 || obs !== prev) begin
          mismatched++;
          $display("FAIL soak_hold: got valid=%b %h expected valid=1 %h", ov, obs, prev);
        end
      end
      if (drn) begin
        compared++;
        exp_r = (q.size() != 0) ? q.pop_front() : '1;
        if (obs !== exp_r) begin
          mismatched++;
          $display("FAIL soak_result: got %h expected %h", obs, exp_r);
        end
      end
      if (acc) begin
        q.push_back(ref64(a, b, m));
        n_acc++;
      end
      stalled = ov && !r;
      prev = obs;
      cyc++;
    end
    compared++;
    if (n_acc != 10000 || q.size() != 0) begin
      mismatched++;
      $display("FAIL soak_complete: got accepted=%0d pending=%0d expected 10000/0", n_acc, q.size());
    end
  endtask

  task automatic test_fp32_and_reset();
    logic [31:0] av[3], bv[3];
    logic [1:0]  mv[3];
    logic [36:0] ev[3];
    logic [36:0] obs;
    logic acc, drn, ov;
    int k = 0, n = 0;
    av[0] = 32'h3F800000; bv[0] = 32'h40000000; mv[0] = 2'b00; ev[0] = {5'b01000, 32'h3F800000};
    av[1] = 32'hC0000000; bv[1] = 32'h3F800000; mv[1] = 2'b10; ev[1] = {5'b01000, 32'h3F800000};
    av[2] = 32'h7FC00001; bv[2] = 32'h7F800001; mv[2] = 2'b01; ev[2] = {5'b00011, 32'h7FC00000};
    for (int c = 0; c < 12 && k < 3; c++) begin
      step32(c < 3, av[(c < 3) ? c : 0], bv[(c < 3) ? c : 0], mv[(c < 3) ? c : 0], 1'b1,
             acc, drn, ov, obs);
      if (drn) begin
        compared++;
        if (obs !== ev[k]) begin
          mismatched++;
          $display("FAIL fp32_result%0d: got %h expected %h", k, obs, ev[k]);
        end
        k++;
      end
    end
    compared++;
    if (k != 3) begin
      mismatched++;
      $display("FAIL fp32_count: got %0d expected 3", k);
    end

    step32(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 1'b0, acc, drn, ov, obs);
    step32(1'b1, 32'h40000000, 32'h3F800000, 2'b00, 1'b0, acc, drn, ov, obs);
    step32(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, acc, drn, ov, obs);
    compared++;
    if (ov !== 1'b1) begin
      mismatched++;
      $display("FAIL fp32_inflight_valid: got %b expected 1", ov);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({ov32, eq32, lt32, gt32, un32, inv32, mm32} !== 38'h0) begin
      mismatched++;
      $display("FAIL fp32_async_reset: got %h expected 0", {ov32, eq32, lt32, gt32, un32, inv32, mm32});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step32(1'b1, 32'h40400000, 32'h40400000, 2'b00, 1'b1, acc, drn, ov, obs);
    for (int c = 0; c < 6; c++) begin
      step32(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, acc, drn, ov, obs);
      if (drn) begin
        n++;
        compared++;
        if (obs !== {5'b10000, 32'h40400000}) begin
          mismatched++;
          $display("FAIL fp32_post_reset: got %h expected %h", obs, {5'b10000, 32'h40400000});
        end
      end
    end
    compared++;
    if (n != 1) begin
      mismatched++;
      $display("FAIL fp32_post_reset_count: got %0d expected 1", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    v64 = 1'b0; a64 = '0; b64 = '0; m64 = 2'b00; ordy64 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; m32 = 2'b00; ordy32 = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_soak();
    test_fp32_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
